timer_countdown: RTL and testbench
==================================

Name: timer_countdown

Overview:
- Consumer side of the keypad/timer input path: receives BCD digits `D` with active-low strobe `loadn` and the 1 Hz tick `pgt_1Hz`.
- Assembles an MM:SS cooking time by shift-in entry, then counts it down once per tick while running.
- Sits between the input-control block and the display/magnetron control; drives four BCD display digits plus run/done status.

Parameters:
- SEC_TENS_MAX, 5, highest value of the seconds-tens digit; it wraps from 0 to this value on borrow.
- MIN_TENS_MAX, 9, saturation value of the minutes-tens digit.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- clearn  input  1  asynchronous active-low reset.
- D  input  4  BCD digit from the keypad encoder.
- loadn  input  1  active-low digit-valid strobe, level; a digit is accepted on its falling edge.
- pgt_1Hz  input  1  1 Hz tick; its rising edge decrements the time.
- startn  input  1  active-low start button, level; acts on its falling edge.
- stopn  input  1  active-low stop/cancel button, level; acts on its falling edge.
- door_open  input  1  active-high door open; level-sensitive.
- min_tens, min_ones, sec_tens, sec_ones  output  4 each  BCD time digits.
- running  output  1  high in RUN (magnetron enable).
- done  output  1  high in DONE.

Behaviour:
- Reset (clearn low, asynchronous):
  - all digits 0; state IDLE; running=0; done=0.
  - edge-detect registers preset to 1 for loadn/startn/stopn and 0 for pgt_1Hz, so no false edge after release.
- Edge detection: one register per input; an event is a single-cycle pulse on the clock after the edge. All outputs are registered, so there is 1-cycle latency from event to output change.
- States: IDLE, RUN, PAUSE, DONE (2-bit encoding).
- Event priority when several occur in one cycle: stop > door_open > start > digit > tick. Only the highest-priority applicable event acts.
- IDLE:
  - Digit event with D ≤ 9 shifts left: min_tens←min_ones, min_ones←sec_tens, sec_tens←sec_ones, sec_ones←D.
  - D > 9 is ignored.
  - Start with time ≠ 0000 and door_open=0 → RUN.
  - Stop clears all digits.
- RUN:
  - Tick decrements by one second. sec_ones borrows 0→9; sec_tens borrows 0→SEC_TENS_MAX; min_ones 0→9; min_tens decrements.
  - The decrement that produces 0000 → DONE in the same update.
  - Stop or door_open → PAUSE, digits held.
  - Digit events ignored.
- PAUSE:
  - Start with door_open=0 → RUN.
  - Stop → IDLE with digits cleared.
  - Digits and ticks ignored.
- DONE:
  - Digits read 0000.
  - Stop or digit event → IDLE; a digit event is also shifted in, so entry restarts immediately.
  - Start ignored unless the optional feature is compiled in.
- Start in IDLE with time 0000 is ignored unless the optional feature is compiled in.
- Entered seconds-tens > SEC_TENS_MAX (e.g. 01:75) are legal. Countdown proceeds from the entered value; after its first borrow, sec_tens wraps to SEC_TENS_MAX.
- Ticks arriving while not in RUN are discarded; no pending tick is stored.

Optional Feature:
- Macro: TIMER_QUICK_ADD_EN.
- With the macro:
  - Start in RUN adds 30 s as a BCD add with carry into minutes, saturating at MIN_TENS_MAX 9:SEC_TENS_MAX 9 (99:59 by default).
  - Start in IDLE or DONE with time 0000 loads 00:30 and enters RUN.
- Without the macro: those start events are ignored exactly as specified above.

Decomposition:
- Shared package holds:
  - state encoding constants: ST_IDLE=0, ST_RUN=1, ST_PAUSE=2, ST_DONE=3.
  - BCD_MAX=9.
  - QUICK_ADD_SECS=30 (as BCD 3,0).
- One natural sub-module: bcd_digit_dec.
  - Inputs: digit, borrow_in, wrap value.
  - Outputs: next digit, borrow_out.
  - Instantiated four times in a chain.
- Edge detectors stay inline.

Test Plan:
- Reset mid-RUN at 01:23 → all digits 0, running=0, done=0 asynchronously, before the next clock edge.
- loadn pulses with D=1,3,0 then D=12 → display 01:30 (D=12 ignored); start → running=1; 3 ticks → 01:27.
- Entry 01:00, start, 1 tick → 00:59; entry 00:02, start, 2 ticks → 00:00, done=1, running=0.
- In RUN, door_open=1 → PAUSE, ticks leave time unchanged; door_open=0 then start → RUN resumes from the held value; stop in PAUSE → IDLE, 00:00.
- Same cycle has stop and tick falling in RUN at 00:01 → PAUSE at 00:01, done stays 0; start and digit in same IDLE cycle → start wins, digit dropped.
- TIMER_QUICK_ADD_EN: start at IDLE 00:00 → RUN 00:30; start at 00:45 in RUN → 01:15; start at 99:50 → 99:59.

Source files
------------

// File: rtl/timer_countdown_pkg.sv
// Shared encodings and constants for the MM:SS countdown timer.
package timer_countdown_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic [3:0] BCD_MAX = 4'd9;

   // Quick-add amount: 30 seconds as BCD tens/ones
   localparam logic [3:0] QUICK_ADD_TENS = 4'd3;
   localparam logic [3:0] QUICK_ADD_ONES = 4'd0;

   typedef struct packed {
      logic [3:0] min_tens;
      logic [3:0] min_ones;
      logic [3:0] sec_tens;
      logic [3:0] sec_ones;
   } bcd_time_t;

endpackage

// File: rtl/timer_countdown_bcd_digit_dec.sv
// One BCD digit of the countdown borrow chain; wraps to `wrap` when borrowing from 0.
module bcd_digit_dec (
   input  logic [3:0] digit,
   input  logic       borrow_in,
   input  logic [3:0] wrap,
   output logic [3:0] digit_next,
   output logic       borrow_out
);

   always_comb begin
      borrow_out = borrow_in & (digit == 4'd0);
      digit_next = digit;
      if (borrow_in) digit_next = (digit == 4'd0) ? wrap : digit - 4'd1;
   end

endmodule

// File: rtl/timer_countdown.sv
// MM:SS keypad-entry countdown timer with IDLE/RUN/PAUSE/DONE control.
// Optional TIMER_QUICK_ADD_EN: start adds 30 s in RUN, or loads 00:30 from an empty time.
module timer_countdown
   import timer_countdown_pkg::*;
#(
   parameter int SEC_TENS_MAX = 5,
   parameter int MIN_TENS_MAX = 9
) (
   input  logic       clock,
   input  logic       clearn,
   input  logic [3:0] D,
   input  logic       loadn,
   input  logic       pgt_1Hz,
   input  logic       startn,
   input  logic       stopn,
   input  logic       door_open,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       running,
   output logic       done
);

   localparam logic [3:0] ST_MAX = 4'(SEC_TENS_MAX);
   localparam logic [3:0] MT_MAX = 4'(MIN_TENS_MAX);

   state_e    state_q, state_d;
   bcd_time_t cnt_q, cnt_d, dec_cnt, shift_cnt;
   logic      running_q, running_d, done_q, done_d;
   logic      loadn_q, startn_q, stopn_q, tick_q;
   logic      digit_ev, start_ev, stop_ev, tick_ev;
   logic      cnt_zero, digit_ok;
   logic [3:0] brw;

   assign digit_ev = loadn_q & ~loadn;
   assign start_ev = startn_q & ~startn;
   assign stop_ev  = stopn_q & ~stopn;
   assign tick_ev  = ~tick_q & pgt_1Hz;

   assign cnt_zero  = (cnt_q == '0);
   assign digit_ok  = (D <= BCD_MAX);
   assign shift_cnt = {cnt_q.min_ones, cnt_q.sec_tens, cnt_q.sec_ones, D};

   bcd_digit_dec u_dec_so (.digit(cnt_q.sec_ones), .borrow_in(1'b1),  .wrap(BCD_MAX),
                           .digit_next(dec_cnt.sec_ones), .borrow_out(brw[0]));
   bcd_digit_dec u_dec_st (.digit(cnt_q.sec_tens), .borrow_in(brw[0]), .wrap(ST_MAX),
                           .digit_next(dec_cnt.sec_tens), .borrow_out(brw[1]));
   bcd_digit_dec u_dec_mo (.digit(cnt_q.min_ones), .borrow_in(brw[1]), .wrap(BCD_MAX),
                           .digit_next(dec_cnt.min_ones), .borrow_out(brw[2]));
   bcd_digit_dec u_dec_mt (.digit(cnt_q.min_tens), .borrow_in(brw[2]), .wrap(MT_MAX),
                           .digit_next(dec_cnt.min_tens), .borrow_out(brw[3]));

`ifdef TIMER_QUICK_ADD_EN
   localparam bcd_time_t QUICK_LOAD = '{4'd0, 4'd0, QUICK_ADD_TENS, QUICK_ADD_ONES};
   bcd_time_t  add_cnt;
   logic [4:0] so_sum, st_sum, mo_sum, mt_sum;
   logic       c0, c1, c2;

   // Ripple BCD add of 30 s; minutes overflow saturates the whole display
   always_comb begin
      so_sum = {1'b0, cnt_q.sec_ones} + {1'b0, QUICK_ADD_ONES};
      c0     = so_sum > {1'b0, BCD_MAX};
      st_sum = {1'b0, cnt_q.sec_tens} + {1'b0, QUICK_ADD_TENS} + {4'd0, c0};
      c1     = st_sum > {1'b0, ST_MAX};
      mo_sum = {1'b0, cnt_q.min_ones} + {4'd0, c1};
      c2     = mo_sum > {1'b0, BCD_MAX};
      mt_sum = {1'b0, cnt_q.min_tens} + {4'd0, c2};
      add_cnt.sec_ones = c0 ? 4'(so_sum - 5'd10) : so_sum[3:0];
      add_cnt.sec_tens = c1 ? 4'(st_sum - ({1'b0, ST_MAX} + 5'd1)) : st_sum[3:0];
      add_cnt.min_ones = c2 ? 4'd0 : mo_sum[3:0];
      add_cnt.min_tens = mt_sum[3:0];
      if (mt_sum > {1'b0, MT_MAX}) add_cnt = '{MT_MAX, BCD_MAX, ST_MAX, BCD_MAX};
   end
`endif

   // Events are tested in priority order; the first applicable one wins
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (stop_ev) cnt_d = '0;
            else if (start_ev && !door_open && !cnt_zero) state_d = ST_RUN;
`ifdef TIMER_QUICK_ADD_EN
            else if (start_ev && !door_open) begin
               cnt_d   = QUICK_LOAD;
               state_d = ST_RUN;
            end
`endif
            else if (digit_ev && digit_ok) cnt_d = shift_cnt;
         end
         ST_RUN: begin
            if (stop_ev || door_open) state_d = ST_PAUSE;
`ifdef TIMER_QUICK_ADD_EN
            else if (start_ev) cnt_d = add_cnt;
`endif
            else if (tick_ev) begin
               // brw[3] means the count was already 0000: hold at zero
               if (!brw[3]) cnt_d = dec_cnt;
               if (brw[3] || dec_cnt == '0) state_d = ST_DONE;
            end
         end
         ST_PAUSE: begin
            if (stop_ev) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (start_ev && !door_open) state_d = ST_RUN;
         end
         ST_DONE: begin
            if (stop_ev) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
`ifdef TIMER_QUICK_ADD_EN
            else if (start_ev && !door_open) begin
               cnt_d   = QUICK_LOAD;
               state_d = ST_RUN;
            end
`endif
            else if (digit_ev) begin
               state_d = ST_IDLE;
               if (digit_ok) cnt_d = shift_cnt;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      running_d = (state_d == ST_RUN);
      done_d    = (state_d == ST_DONE);
   end

   always_ff @(posedge clock or negedge clearn) begin
      if (!clearn) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
         loadn_q   <= 1'b1;
         startn_q  <= 1'b1;
         stopn_q   <= 1'b1;
         tick_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         running_q <= running_d;
         done_q    <= done_d;
         loadn_q   <= loadn;
         startn_q  <= startn;
         stopn_q   <= stopn;
         tick_q    <= pgt_1Hz;
      end
   end

   assign min_tens = cnt_q.min_tens;
   assign min_ones = cnt_q.min_ones;
   assign sec_tens = cnt_q.sec_tens;
   assign sec_ones = cnt_q.sec_ones;
   assign running  = running_q;
   assign done     = done_q;

endmodule

// File: tb/tb_timer_countdown.sv
// Bench for timer_countdown: directed scenarios plus random stimulus against a minutes/seconds model.
module tb_timer_countdown;

   localparam int STM = 5;

   logic       clock = 1'b0;
   logic       clearn = 1'b0;
   logic [3:0] D = 4'd0;
   logic       loadn = 1'b1, startn = 1'b1, stopn = 1'b1, pgt_1Hz = 1'b0, door_open = 1'b0;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic       running, done;

   timer_countdown dut (
      .clock(clock), .clearn(clearn), .D(D), .loadn(loadn), .pgt_1Hz(pgt_1Hz),
      .startn(startn), .stopn(stopn), .door_open(door_open),
      .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
      .running(running), .done(done)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mstate_e;
   mstate_e ms;
   int      mm, ss;
   bit      p_load, p_start, p_stop, p_tick;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] dut_out();
      return {14'd0, min_tens, min_ones, sec_tens, sec_ones, running, done};
   endfunction

   function automatic logic [31:0] model_out();
      logic [3:0] a, b, c, d;
      a = 4'(mm / 10); b = 4'(mm % 10); c = 4'(ss / 10); d = 4'(ss % 10);
      return {14'd0, a, b, c, d, ms == M_RUN, ms == M_DONE};
   endfunction

   function automatic logic [31:0] want(input logic [15:0] disp, input bit r, input bit dn);
      return {14'd0, disp, r, dn};
   endfunction

   task automatic model_reset();
      ms = M_IDLE; mm = 0; ss = 0;
      p_load = 1; p_start = 1; p_stop = 1; p_tick = 0;
   endtask

   // Time kept as minutes + seconds; entry is a 4-digit decimal shift register
   task automatic model_clk();
      bit ev_load, ev_start, ev_stop, ev_tick, zero;
      int n;
      ev_load  = p_load && !loadn;
      ev_start = p_start && !startn;
      ev_stop  = p_stop && !stopn;
      ev_tick  = !p_tick && pgt_1Hz;
      zero     = (mm == 0 && ss == 0);
      n        = ((mm * 100 + ss) * 10 + int'(D)) % 10000;
      case (ms)
         M_IDLE:
            if (ev_stop) begin mm = 0; ss = 0; end
            else if (ev_start && !door_open && !zero) ms = M_RUN;
            else if (ev_load && D <= 9) begin mm = n / 100; ss = n % 100; end
         M_RUN:
            if (ev_stop || door_open) ms = M_PAUSE;
            else if (ev_tick) begin
               if (ss > 0) ss--;
               else begin mm--; ss = STM * 10 + 9; end
               if (mm == 0 && ss == 0) ms = M_DONE;
            end
         M_PAUSE:
            if (ev_stop) begin ms = M_IDLE; mm = 0; ss = 0; end
            else if (ev_start && !door_open) ms = M_RUN;
         M_DONE:
            if (ev_stop) begin ms = M_IDLE; mm = 0; ss = 0; end
            else if (ev_load) begin
               ms = M_IDLE;
               if (D <= 9) begin mm = n / 100; ss = n % 100; end
            end
      endcase
      p_load = loadn; p_start = startn; p_stop = stopn; p_tick = pgt_1Hz;
   endtask

   task automatic step(input string tag);
      @(posedge clock);
      #1;
      model_clk();
      chk(tag, dut_out(), model_out());
   endtask

   task automatic key(input logic [3:0] d);
      D = d; loadn = 1'b0; step("key");
      loadn = 1'b1; step("key_rel");
   endtask

   task automatic press_start();
      startn = 1'b0; step("start");
      startn = 1'b1; step("start_rel");
   endtask

   task automatic press_stop();
      stopn = 1'b0; step("stop");
      stopn = 1'b1; step("stop_rel");
   endtask

   task automatic tick();
      pgt_1Hz = 1'b1; step("tick");
      pgt_1Hz = 1'b0; step("tick_rel");
   endtask

   initial begin
      model_reset();
      #3;
      chk("reset_out", dut_out(), 32'd0);
      #9 clearn = 1'b1;

      press_start();
      chk("start_at_zero", dut_out(), want(16'h0000, 0, 0));

      key(4'd1); key(4'd3); key(4'd0); key(4'd12);
      chk("entry_0130", dut_out(), want(16'h0130, 0, 0));
      press_start();
      chk("run_0130", dut_out(), want(16'h0130, 1, 0));
      repeat (3) tick();
      chk("run_0127", dut_out(), want(16'h0127, 1, 0));

      press_stop(); press_stop();
      chk("cleared", dut_out(), want(16'h0000, 0, 0));
      key(4'd1); key(4'd0); key(4'd0);
      press_start(); tick();
      chk("borrow_0059", dut_out(), want(16'h0059, 1, 0));
      press_stop(); press_stop();
      key(4'd2); press_start(); tick(); tick();
      chk("done_0000", dut_out(), want(16'h0000, 0, 1));

      key(4'd5);
      chk("done_digit", dut_out(), want(16'h0005, 0, 0));
      key(4'd0); key(4'd0); press_start();
      door_open = 1'b1; step("door");
      chk("door_pause", dut_out(), want(16'h0500, 0, 0));
      tick();
      chk("pause_tick", dut_out(), want(16'h0500, 0, 0));
      door_open = 1'b0; step("door_close");
      press_start(); tick();
      chk("resume_0459", dut_out(), want(16'h0459, 1, 0));
      press_stop(); press_stop();
      chk("pause_stop", dut_out(), want(16'h0000, 0, 0));

      key(4'd5); press_start(); repeat (4) tick();
      stopn = 1'b0; pgt_1Hz = 1'b1; step("stop_tick");
      stopn = 1'b1; pgt_1Hz = 1'b0; step("stop_tick_rel");
      chk("stop_beats_tick", dut_out(), want(16'h0001, 0, 0));
      press_stop();

      key(4'd1); key(4'd7); key(4'd5); press_start();
      repeat (76) tick();
      chk("sec_tens_75", dut_out(), want(16'h0059, 1, 0));
      press_stop(); press_stop();

      key(4'd1); key(4'd2);
      startn = 1'b0; loadn = 1'b0; D = 4'd7; step("start_digit");
      startn = 1'b1; loadn = 1'b1; step("start_digit_rel");
      chk("start_beats_digit", dut_out(), want(16'h0012, 1, 0));
      press_stop(); press_stop();

      key(4'd1); key(4'd2); key(4'd3); press_start();
      chk("run_0123", dut_out(), want(16'h0123, 1, 0));
      #2 clearn = 1'b0;
      #1 chk("async_reset", dut_out(), 32'd0);
      model_reset();
      @(posedge clock); #3 clearn = 1'b1;

      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 99) < 30) loadn = ~loadn;
         if ($urandom_range(0, 99) < 10) startn = ~startn;
         if ($urandom_range(0, 99) < 3)  stopn = ~stopn;
         if ($urandom_range(0, 99) < 25) pgt_1Hz = ~pgt_1Hz;
         if ($urandom_range(0, 99) < 2)  door_open = ~door_open;
         D = 4'($urandom_range(0, 11));
         step("random");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
